// File: rtl/sram_bank_pkg.sv
// Shared constants, types and helpers for the two-port register-file bank.
// SRAM_ZERO_REG_EN makes address 0 a hard-wired zero word.
package sram_bank_pkg;

    localparam int PHASES      = 10;
    localparam int WIDTH       = 16;
    localparam int DEPTH       = 32;
    localparam int ADDR_W      = $clog2(DEPTH);
    localparam int READ_PHASE  = 7;
    localparam int WRITE_PHASE = 9;
    localparam int STEP_W      = 5;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [STEP_W-1:0] step_t;

    typedef struct packed {
        logic read_rise;
        logic write_rise;
        logic read_fall;
    } seq_strobe_t;

    function automatic logic is_zero_reg(input addr_t addr);
`ifdef SRAM_ZERO_REG_EN
        return addr == '0;
`else
        return addr != addr;
`endif
    endfunction

endpackage

// File: rtl/bennett_phase_seq.sv
// Ten-phase Bennett clock sequencer: phases rise 0..9 then fall 9..0.
// Exports one-hot read/write rise strobes and the read-phase fall strobe.
module bennett_phase_seq
    import sram_bank_pkg::*;
#(
    parameter int N_PHASES = 10
) (
    input  logic                clk,
    input  logic                reset,
    output logic [N_PHASES-1:0] clkpos,
    output logic                inst_flag,
    output seq_strobe_t         strobe
);

    localparam int    STEPS     = 2 * N_PHASES;
    localparam step_t LAST      = step_t'(STEPS - 1);
    localparam step_t RD_RISE   = step_t'(READ_PHASE);
    localparam step_t WR_RISE   = step_t'(WRITE_PHASE);
    localparam step_t RD_FALL   = step_t'(STEPS - 1 - READ_PHASE);

    step_t               step;
    logic [N_PHASES-1:0] set_mask;
    logic [N_PHASES-1:0] clr_mask;

    // Phase k rises on step k and falls on step 19-k.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int k = 0; k < N_PHASES; k++) begin
            set_mask[k] = (step == step_t'(k));
            clr_mask[k] = (step == step_t'(STEPS - 1 - k));
        end
    end

    always_comb begin
        strobe            = '0;
        strobe.read_rise  = (step == RD_RISE);
        strobe.write_rise = (step == WR_RISE);
        strobe.read_fall  = (step == RD_FALL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step      <= '0;
            clkpos    <= '0;
            inst_flag <= 1'b0;
        end else begin
            clkpos    <= (clkpos | set_mask) & ~clr_mask;
            inst_flag <= (step == LAST);
            if (step == LAST) begin
                step <= '0;
            end else begin
                step <= step + step_t'(1);
            end
        end
    end

endmodule

// File: rtl/sram_two_port_bank.sv
// 32x16 two-port register-file bank gated by the Bennett phase sequencer.
// SRAM_ZERO_REG_EN: address 0 reads 0 and ignores writes.
module sram_two_port_bank
    import sram_bank_pkg::*;
#(
    parameter int PHASES = sram_bank_pkg::PHASES,
    parameter int WIDTH  = sram_bank_pkg::WIDTH,
    parameter int DEPTH  = sram_bank_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    input  logic                     read_en,
    input  logic                     write_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic [PHASES-1:0]        clkpos,
    output logic                     inst_flag
);

    seq_strobe_t      strobe;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             wr_ok;

    bennett_phase_seq #(
        .N_PHASES (PHASES)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .clkpos    (clkpos),
        .inst_flag (inst_flag),
        .strobe    (strobe)
    );

    always_comb begin
        rd_a  = is_zero_reg(addr_t'(addr_a)) ? '0 : mem[addr_a];
        rd_b  = is_zero_reg(addr_t'(addr_b)) ? '0 : mem[addr_b];
        wr_ok = strobe.write_rise & write_en
              & ~is_zero_reg(addr_t'(addr_a));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[addr_a] <= din;
        end
    end

    // Outputs are only driven while phase 7 is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_a <= '0;
            out_b <= '0;
        end else if (strobe.read_rise) begin
            out_a <= read_en ? rd_a : '0;
            out_b <= read_en ? rd_b : '0;
        end else if (strobe.read_fall) begin
            out_a <= '0;
            out_b <= '0;
        end
    end

endmodule

// File: tb/tb_sram_two_port_bank.sv
// Directed self-checking bench for sram_two_port_bank.
// Build with +define+SRAM_ZERO_REG_EN to exercise the zero-register variant.
module tb_sram_two_port_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  addr_a = '0;
    logic [4:0]  addr_b = '0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [9:0]  clkpos;
    logic        inst_flag;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    sram_two_port_bank dut (
        .clk       (clk),
        .reset     (reset),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .read_en   (read_en),
        .write_en  (write_en),
        .din       (din),
        .out_a     (out_a),
        .out_b     (out_b),
        .clkpos    (clkpos),
        .inst_flag (inst_flag)
    );

    always #5 clk = ~clk;

    // One rising edge; cyc counts edges since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Return with the next edge being the one at step s.
    task automatic goto_step(input int s);
        int guard;
        guard = 0;
        while ((cyc % 20) != s && guard < 25) begin
            tick();
            guard++;
        end
        vectors++;
        if ((cyc % 20) != s) begin
            miscompares++;
            $display("FAIL goto_step: at step %0d, wanted %0d", cyc % 20, s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if ({clkpos, inst_flag, out_a, out_b} !== 43'd0) begin
            miscompares++;
            $display("FAIL reset_state: clkpos=%h flag=%b a=%h b=%h, want 0",
                     clkpos, inst_flag, out_a, out_b);
        end
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_sequencer();
        logic [9:0] exp_pos;
        logic       exp_flag;
        int         s;
        for (int i = 0; i < 40; i++) begin
            s = cyc % 20;
            tick();
            exp_pos  = (s < 10) ? 10'((1 << (s + 1)) - 1)
                                : 10'((1 << (19 - s)) - 1);
            exp_flag = (s == 19);
            vectors++;
            if (clkpos !== exp_pos) begin
                miscompares++;
                $display("FAIL clkpos step%0d: got %h want %h", s, clkpos, exp_pos);
            end
            vectors++;
            if (inst_flag !== exp_flag) begin
                miscompares++;
                $display("FAIL inst_flag step%0d: got %b want %b", s, inst_flag, exp_flag);
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] exp_a;
        goto_step(9);
        addr_a = 5'd1;
        din = 16'hAAAA;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        goto_step(7);
        addr_a = 5'd1;
        addr_b = 5'd0;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        for (int s = 7; s <= 12; s++) begin
            if (s > 7) tick();
            exp_a = (s < 12) ? 16'hAAAA : 16'h0000;
            vectors++;
            if (out_a !== exp_a || out_b !== 16'h0000) begin
                miscompares++;
                $display("FAIL write_read step%0d: a=%h b=%h want a=%h b=0000",
                         s, out_a, out_b, exp_a);
            end
        end
    endtask

    task automatic test_write_wrong_step();
        goto_step(8);
        addr_a = 5'd5;
        din = 16'hBEEF;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        tick();
        goto_step(7);
        addr_a = 5'd5;
        addr_b = 5'd5;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        vectors++;
        if (out_a !== 16'h0000 || out_b !== 16'h0000) begin
            miscompares++;
            $display("FAIL step8_write: a=%h b=%h want 0000", out_a, out_b);
        end
    endtask

    task automatic test_same_cycle();
        goto_step(9);
        addr_a = 5'd3;
        din = 16'h1234;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        goto_step(7);
        addr_a = 5'd3;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        vectors++;
        if (out_a !== 16'h1234) begin
            miscompares++;
            $display("FAIL same_cycle_old: got %h want 1234", out_a);
        end
        goto_step(9);
        din = 16'h5678;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        vectors++;
        if (out_a !== 16'h1234) begin
            miscompares++;
            $display("FAIL same_cycle_hold: got %h want 1234", out_a);
        end
        goto_step(7);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        vectors++;
        if (out_a !== 16'h5678) begin
            miscompares++;
            $display("FAIL next_cycle_new: got %h want 5678", out_a);
        end
    endtask

    // read_en held high for a whole cycle; only step 7 captures.
    task automatic test_same_addr_held();
        goto_step(0);
        addr_a = 5'd1;
        addr_b = 5'd1;
        read_en = 1'b1;
        repeat (7) tick();
        vectors++;
        if (out_a !== 16'h0000) begin
            miscompares++;
            $display("FAIL held_pre7: got %h want 0000", out_a);
        end
        tick();
        vectors++;
        if (out_a !== 16'hAAAA || out_b !== 16'hAAAA) begin
            miscompares++;
            $display("FAIL same_addr: a=%h b=%h want AAAA", out_a, out_b);
        end
        repeat (5) tick();
        vectors++;
        if (out_a !== 16'h0000 || out_b !== 16'h0000) begin
            miscompares++;
            $display("FAIL held_fall12: a=%h b=%h want 0000", out_a, out_b);
        end
        read_en = 1'b0;
    endtask

    task automatic test_zero_addr();
        logic [15:0] exp_z;
`ifdef SRAM_ZERO_REG_EN
        exp_z = 16'h0000;
`else
        exp_z = 16'hFFFF;
`endif
        goto_step(9);
        addr_a = 5'd0;
        din = 16'hFFFF;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        goto_step(7);
        addr_a = 5'd0;
        addr_b = 5'd0;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        vectors++;
        if (out_a !== exp_z || out_b !== exp_z) begin
            miscompares++;
            $display("FAIL zero_addr: a=%h b=%h want %h", out_a, out_b, exp_z);
        end
    endtask

    task automatic test_reset_mid_cycle();
        goto_step(8);
        addr_a = 5'd2;
        din = 16'h2222;
        write_en = 1'b1;
        tick();
        vectors++;
        if (clkpos !== 10'h1FF) begin
            miscompares++;
            $display("FAIL pre_reset_pos: got %h want 1ff", clkpos);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (clkpos !== 10'h000 || inst_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: clkpos=%h flag=%b want 000/0", clkpos, inst_flag);
        end
        reset = 1'b0;
        write_en = 1'b0;
        cyc = 0;
        tick();
        vectors++;
        if (clkpos !== 10'h001) begin
            miscompares++;
            $display("FAIL restart_step0: got %h want 001", clkpos);
        end
        goto_step(7);
        addr_a = 5'd2;
        addr_b = 5'd1;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        vectors++;
        if (out_a !== 16'h0000 || out_b !== 16'h0000) begin
            miscompares++;
            $display("FAIL post_reset_mem: a=%h b=%h want 0000", out_a, out_b);
        end
    endtask

    initial begin
        test_reset();
        test_sequencer();
        test_write_read();
        test_write_wrong_step();
        test_same_cycle();
        test_same_addr_held();
        test_zero_addr();
        test_reset_mid_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
